// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset CPU: sequences IF/ID/EX/MEM/WB over a shared
// ALU and a single unified memory port, with cycle/retire counters and a memory watchdog.
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       op_code,
  input  logic [2:0]       funct3,
  input  logic             br_cond,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_HALT  = 5'b11100;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state_reg, state_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic              illegal_reg, bus_err_reg;
  logic              illegal_set, bus_err_set;
  logic              wd_expire;
  logic [CNT_W-1:0]  cycle_cnt_reg, instr_cnt_reg;

  // Branch outcome arrives already resolved on br_cond, so funct3 carries no extra information here.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign wd_expire = (TIMEOUT != 0) && !mem_ack && (wd_reg == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_next   = state_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    illegal_set  = 1'b0;
    bus_err_set  = 1'b0;
    case (state_reg)
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we      = 1'b1;
          state_next = S_ID;
        end else if (wd_expire) begin
          mem_req     = 1'b0;
          bus_err_set = 1'b1;
          state_next  = S_HALT;
        end
      end
      S_ID: begin
        case (op_code)
          OP_HALT: state_next = S_HALT;
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_next = S_EX;
          default: begin
            illegal_set = 1'b1;
            state_next  = S_HALT;
          end
        endcase
      end
      S_EX: begin
        state_next = S_WB;
        case (op_code)
          OP_R, OP_JAL, OP_LUI: ;
          OP_I, OP_JALR: alu_b_sel = 1'b1;
          OP_LOAD, OP_STORE: begin
            alu_b_sel  = 1'b1;
            state_next = S_MEM;
          end
          OP_BR: begin
            pc_we      = 1'b1;
            pc_sel     = br_cond ? 2'd1 : 2'd0;
            state_next = S_IF;
          end
          OP_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          default: begin
            illegal_set = 1'b1;
            state_next  = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        alu_b_sel    = 1'b1;
        mem_we       = (op_code == OP_STORE);
        if (mem_ack) begin
          if (op_code == OP_STORE) begin
            pc_we      = 1'b1;
            state_next = S_IF;
          end else begin
            state_next = S_WB;
          end
        end else if (wd_expire) begin
          mem_req     = 1'b0;
          mem_we      = 1'b0;
          bus_err_set = 1'b1;
          state_next  = S_HALT;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        state_next = S_IF;
        case (op_code)
          OP_LUI:  wb_sel = 2'd3;
          OP_JAL: begin
            wb_sel = 2'd2;
            pc_sel = 2'd1;
          end
          OP_JALR: begin
            wb_sel    = 2'd2;
            pc_sel    = 2'd2;
            alu_b_sel = 1'b1;
          end
          OP_LOAD: wb_sel = 2'd1;
          default: ;
        endcase
      end
      S_HALT: ;
      default: begin
        illegal_set = 1'b1;
        state_next  = S_HALT;
      end
    endcase
    if (rst) begin
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      reg_we = 1'b0;
      mem_we = 1'b0;
    end
  end

  // Watchdog only runs while a memory request stays pending in the same state.
  always_comb begin
    wd_next = wd_reg + WD_W'(1);
    if (state_next != state_reg || mem_ack || !(state_reg == S_IF || state_reg == S_MEM)) begin
      wd_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IF;
      wd_reg        <= '0;
      illegal_reg   <= 1'b0;
      bus_err_reg   <= 1'b0;
      cycle_cnt_reg <= '0;
      instr_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
      if (illegal_set) illegal_reg <= 1'b1;
      if (bus_err_set) bus_err_reg <= 1'b1;
      if (state_reg != S_HALT) cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      if (pc_we) instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
    end
  end

  assign state     = state_reg;
  assign halted    = (state_reg == S_HALT);
  assign illegal   = illegal_reg;
  assign bus_err   = bus_err_reg;
  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-scenario tasks with inline checks, plus a
// retire scoreboard that matches each pc_we pulse against a queued expectation.
module tb_multicycle_ctrl;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       op_code;
  logic [2:0]       funct3;
  logic             br_cond;
  logic             mem_ack;
  logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]       pc_sel, wb_sel;
  logic             alu_a_sel, alu_b_sel, reg_we;
  logic [2:0]       state;
  logic             halted, illegal, bus_err;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic       reg_we;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .br_cond(br_cond),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .reg_we(reg_we), .wb_sel(wb_sel), .state(state),
    .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  // Retire scoreboard: every pc_we pulse pops one expectation, including latency since fetch start.
  initial begin
    int   lat_cnt;
    exp_t e;
    lat_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat_cnt = 0;
      end else begin
        if (state != 3'd5) lat_cnt++;
        if (pc_we) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL retire_unexpected got=pc_we state=%0d exp=no_retire", state);
          end else begin
            e = exp_q.pop_front();
            if (pc_sel !== e.pc_sel || wb_sel !== e.wb_sel || reg_we !== e.reg_we || lat_cnt != e.lat) begin
              failures++;
              $display("FAIL retire got pc_sel=%0d wb_sel=%0d reg_we=%0b lat=%0d exp pc_sel=%0d wb_sel=%0d reg_we=%0b lat=%0d",
                       pc_sel, wb_sel, reg_we, lat_cnt, e.pc_sel, e.wb_sel, e.reg_we, e.lat);
            end
          end
          lat_cnt = 0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ack = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b1; op_code = 5'b01100; funct3 = 3'd0; br_cond = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (state !== 3'd0 || cycle_cnt !== '0 || instr_cnt !== '0) begin
      failures++;
      $display("FAIL reset_state got state=%0d cyc=%0d ins=%0d exp 0/0/0", state, cycle_cnt, instr_cnt);
    end
    checks++;
    if ({halted, illegal, bus_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {halted, illegal, bus_err});
    end
    checks++;
    if ({ir_we, pc_we, reg_we, mem_we} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_enables got=%b exp=0000", {ir_we, pc_we, reg_we, mem_we});
    end
    rst = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_rtype();
    int st[4];
    st = '{0, 1, 2, 4};
    do_reset();
    op_code = 5'b01100;
    exp_q.push_back('{2'd0, 2'd0, 1'b1, 4});
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1;
      #1;
      checks++;
      if (state !== st[i] || reg_we !== (i == 3) || ir_we !== (i == 0)) begin
        failures++;
        $display("FAIL rtype_cycle%0d got state=%0d reg_we=%0b ir_we=%0b exp state=%0d", i, state, reg_we, ir_we, st[i]);
      end
      next_cycle();
    end
    checks++;
    if (state !== 3'd0 || instr_cnt !== 32'd1 || cycle_cnt !== 32'd4) begin
      failures++;
      $display("FAIL rtype_counters got state=%0d ins=%0d cyc=%0d exp 0/1/4", state, instr_cnt, cycle_cnt);
    end
  endtask

  task automatic test_load();
    int st[11];
    int ack[11];
    st  = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
    ack = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
    do_reset();
    op_code = 5'b00000;
    exp_q.push_back('{2'd0, 2'd1, 1'b1, 11});
    for (int i = 0; i < 11; i++) begin
      mem_ack = ack[i][0];
      #1;
      checks++;
      if (state !== st[i] || mem_req !== (st[i] == 0 || st[i] == 3) ||
          mem_addr_sel !== (st[i] == 3) || mem_we !== 1'b0 || ir_we !== (i == 3)) begin
        failures++;
        $display("FAIL load_cycle%0d got state=%0d req=%0b asel=%0b we=%0b ir_we=%0b exp state=%0d",
                 i, state, mem_req, mem_addr_sel, mem_we, ir_we, st[i]);
      end
      next_cycle();
    end
    checks++;
    if (instr_cnt !== 32'd1 || cycle_cnt !== 32'd11) begin
      failures++;
      $display("FAIL load_counters got ins=%0d cyc=%0d exp 1/11", instr_cnt, cycle_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    op_code = 5'b11000;
    for (int b = 1; b >= 0; b--) begin
      br_cond = b[0];
      exp_q.push_back('{b[0] ? 2'd1 : 2'd0, 2'd0, 1'b0, 3});
      for (int i = 0; i < 3; i++) begin
        mem_ack = 1'b1;
        #1;
        checks++;
        if (state !== 3'(i) || reg_we !== 1'b0 || pc_we !== (i == 2) || alu_b_sel !== 1'b0) begin
          failures++;
          $display("FAIL branch%0d_cycle%0d got state=%0d reg_we=%0b pc_we=%0b bsel=%0b exp state=%0d",
                   b, i, state, reg_we, pc_we, alu_b_sel, i);
        end
        next_cycle();
      end
    end
    br_cond = 1'b0;
    checks++;
    if (instr_cnt !== 32'd2 || cycle_cnt !== 32'd6) begin
      failures++;
      $display("FAIL branch_counters got ins=%0d cyc=%0d exp 2/6", instr_cnt, cycle_cnt);
    end
  endtask

  task automatic test_store_illegal();
    do_reset();
    op_code = 5'b01000;
    exp_q.push_back('{2'd0, 2'd0, 1'b0, 4});
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1;
      #1;
      checks++;
      if (state !== 3'(i) || mem_we !== (i == 3) || pc_we !== (i == 3)) begin
        failures++;
        $display("FAIL store_cycle%0d got state=%0d mem_we=%0b pc_we=%0b exp state=%0d", i, state, mem_we, pc_we, i);
      end
      next_cycle();
    end
    op_code = 5'b11111;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (state !== 3'd5 || halted !== 1'b1 || illegal !== 1'b1 || bus_err !== 1'b0 || cycle_cnt !== 32'd6) begin
      failures++;
      $display("FAIL illegal_halt got state=%0d h=%0b i=%0b b=%0b cyc=%0d exp 5/1/1/0/6",
               state, halted, illegal, bus_err, cycle_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      mem_ack = 1'b1;
      #1;
      checks++;
      if ({ir_we, pc_we, reg_we, mem_we, mem_req} !== 5'b0) begin
        failures++;
        $display("FAIL halt_enables%0d got=%b exp=00000", i, {ir_we, pc_we, reg_we, mem_we, mem_req});
      end
      next_cycle();
    end
    checks++;
    if (cycle_cnt !== 32'd6 || instr_cnt !== 32'd1 || state !== 3'd5) begin
      failures++;
      $display("FAIL halt_frozen got cyc=%0d ins=%0d state=%0d exp 6/1/5", cycle_cnt, instr_cnt, state);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    op_code = 5'b01100;
    for (int i = 0; i < TIMEOUT; i++) begin
      mem_ack = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || bus_err !== 1'b0 || ir_we !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait%0d got state=%0d bus_err=%0b exp state=0 bus_err=0", i, state, bus_err);
      end
      next_cycle();
    end
    checks++;
    if (state !== 3'd5 || bus_err !== 1'b1 || illegal !== 1'b0 || halted !== 1'b1 || cycle_cnt !== 32'(TIMEOUT)) begin
      failures++;
      $display("FAIL timeout_halt got state=%0d b=%0b i=%0b h=%0b cyc=%0d exp 5/1/0/1/%0d",
               state, bus_err, illegal, halted, cycle_cnt, TIMEOUT);
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || {halted, illegal, bus_err} !== 3'b000 || cycle_cnt !== '0 || instr_cnt !== '0) begin
      failures++;
      $display("FAIL timeout_reset got state=%0d flags=%b cyc=%0d ins=%0d exp 0/000/0/0",
               state, {halted, illegal, bus_err}, cycle_cnt, instr_cnt);
    end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    op_code = 5'b01000;
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 0);
      next_cycle();
    end
    rst = 1'b1; mem_ack = 1'b1;
    #1;
    checks++;
    if (state !== 3'd3 || mem_we !== 1'b0 || pc_we !== 1'b0) begin
      failures++;
      $display("FAIL midreset_enables got state=%0d mem_we=%0b pc_we=%0b exp 3/0/0", state, mem_we, pc_we);
    end
    next_cycle();
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || instr_cnt !== '0) begin
      failures++;
      $display("FAIL midreset_after got state=%0d ins=%0d exp 0/0", state, instr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops[5];
    logic [1:0] psel[5];
    logic [1:0] wsel[5];
    logic [1:0] absel[5];
    ops   = '{5'b00100, 5'b11011, 5'b11001, 5'b00101, 5'b01101};
    psel  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    wsel  = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd3};
    absel = '{2'b01, 2'b00, 2'b01, 2'b11, 2'b00};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      op_code = ops[k];
      exp_q.push_back('{psel[k], wsel[k], 1'b1, 4});
      for (int i = 0; i < 4; i++) begin
        mem_ack = 1'b1;
        #1;
        checks++;
        if (state !== ((i == 3) ? 3'd4 : 3'(i))) begin
          failures++;
          $display("FAIL b2b_op%0d_state%0d got=%0d", k, i, state);
        end
        if (i == 2) begin
          checks++;
          if ({alu_a_sel, alu_b_sel} !== absel[k]) begin
            failures++;
            $display("FAIL b2b_op%0d_alusel got=%b exp=%b", k, {alu_a_sel, alu_b_sel}, absel[k]);
          end
        end
        next_cycle();
      end
    end
    op_code = 5'b11100;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (state !== 3'd5 || halted !== 1'b1 || illegal !== 1'b0 || instr_cnt !== 32'd5 || cycle_cnt !== 32'd22) begin
      failures++;
      $display("FAIL b2b_halt got state=%0d h=%0b i=%0b ins=%0d cyc=%0d exp 5/1/0/5/22",
               state, halted, illegal, instr_cnt, cycle_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; op_code = '0; funct3 = '0; br_cond = 1'b0; mem_ack = 1'b0;
    test_reset();
    test_rtype();
    test_load();
    test_branch();
    test_store_illegal();
    test_timeout();
    test_reset_mid_store();
    test_back_to_back();
    repeat (2) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=no_finish exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
